// File: rtl/riscv_pkg.sv
// Shared register-file types: data width, register address width and the
// writeback request carried through the multi-cycle result buffer.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; DEPTH must be a power of two so the
// pointers wrap by natural overflow.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  wb_req_t       i_wdata,
  input  logic          i_pop,
  output wb_req_t       o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  wb_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and multi-cycle results onto the regfile write port
// with anti-starvation of buffered results. WB_BYPASS_EN adds decode forwarding ports.
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_alu_valid,
  output logic                  o_alu_ready,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]       i_alu_data,
  input  logic                  i_ext_valid,
  output logic                  o_ext_ready,
  input  logic [REG_ADDR_W-1:0] i_ext_rd,
  input  logic [XLEN-1:0]       i_ext_data,
`ifdef WB_BYPASS_EN
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  output logic                  o_rs1_fwd_hit,
  output logic                  o_rs2_fwd_hit,
  output logic [XLEN-1:0]       o_rs1_fwd_data,
  output logic [XLEN-1:0]       o_rs2_fwd_data,
`endif
  output logic                  o_rd_we,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]       o_rd_data,
  output logic [CW-1:0]         o_fifo_count
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic                  r_rd_we;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic [XLEN-1:0]       r_rd_data;
  logic [SW-1:0]         r_starve;

  wb_req_t w_head, w_win;
  logic    w_full, w_empty, w_force, w_pop, w_pass, w_push, w_alu_win, w_win_vld;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ('{rd: i_ext_rd, data: i_ext_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_fifo_count)
  );

  assign w_force   = (r_starve == SW'(STARVE_MAX)) && !w_empty;
  assign w_alu_win = i_alu_valid && !w_force;
  assign w_pop     = !w_empty && (w_force || !i_alu_valid);
  // Pass-through only when nothing is buffered, so ordering is never violated.
  assign w_pass    = w_empty && !i_alu_valid && i_ext_valid;
  assign w_push    = i_ext_valid && !w_full && !w_pass;

  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    if (w_pop) begin
      w_win     = w_head;
      w_win_vld = 1'b1;
    end else if (w_alu_win) begin
      w_win     = '{rd: i_alu_rd, data: i_alu_data};
      w_win_vld = 1'b1;
    end else if (w_pass) begin
      w_win     = '{rd: i_ext_rd, data: i_ext_data};
      w_win_vld = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_empty || w_pop) begin
      r_starve <= '0;
    end else if (w_alu_win && r_starve != SW'(STARVE_MAX)) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // Address/data only move on real writes; x0 winners are consumed silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_we   <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else begin
      r_rd_we <= w_win_vld && (w_win.rd != '0);
      if (w_win_vld && (w_win.rd != '0)) begin
        r_rd_addr <= w_win.rd;
        r_rd_data <= w_win.data;
      end
    end
  end

  assign o_alu_ready = !w_force;
  assign o_ext_ready = !w_full;
  assign o_rd_we     = r_rd_we;
  assign o_rd_addr   = r_rd_addr;
  assign o_rd_data   = r_rd_data;

`ifdef WB_BYPASS_EN
  assign o_rs1_fwd_hit  = r_rd_we && (r_rd_addr == i_rs1_addr) && (i_rs1_addr != '0);
  assign o_rs2_fwd_hit  = r_rd_we && (r_rd_addr == i_rs2_addr) && (i_rs2_addr != '0);
  assign o_rs1_fwd_data = r_rd_data;
  assign o_rs2_fwd_data = r_rd_data;
`endif
endmodule
